// File: rtl/btn_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel button conditioner.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that never collapses to zero bits for a terminal count of 1.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_db_channel.sv
// One button channel: 2-FF synchroniser, N-sample debounce, edge pulses
// and an optional hold-to-repeat FSM, all advancing on the shared tick.
module btn_db_channel
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int            CW       = cntWidth(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A single sample agreeing with the current level restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int            HW        = cntWidth(max(HOLD_TICKS, REPEAT_TICKS));
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_TICKS - 1);

    rpt_state_e    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          rep_q, rep_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= REL;
        hcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        rep_q   <= rep_d;
      end
    end

    // The fall decision is taken first so a release never emits a repeat.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      rep_d   = 1'b0;
      if (fall_d) begin
        state_d = REL;
        hcnt_d  = '0;
      end else begin
        unique case (state_q)
          REL: begin
            if (rise_d) begin
              state_d = HOLD;
              hcnt_d  = '0;
            end
          end
          HOLD: begin
            if (tick_i) begin
              if (hcnt_q == HOLD_LAST) begin
                rep_d   = 1'b1;
                state_d = RPT;
                hcnt_d  = '0;
              end else begin
                hcnt_d = hcnt_q + 1'b1;
              end
            end
          end
          RPT: begin
            if (tick_i) begin
              if (hcnt_q == RPT_LAST) begin
                rep_d  = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hcnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = REL;
            hcnt_d  = '0;
          end
        endcase
      end
    end

    assign repeat_o = rep_q;
  end else begin : g_no_repeat
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/btn_debounce_array.sv
// N_CH-wide button conditioner: one shared sample-tick divider feeding
// independent debounce/repeat channels.
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CLK_DIV      = 100,
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_tick
);

  localparam int            DW       = cntWidth(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  assign tick   = (div_q == DIV_LAST);
  assign o_tick = tick;

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    btn_db_channel #(
      .STABLE_CNT  (STABLE_CNT),
      .REPEAT_EN   (REPEAT_EN),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .btn_i   (i_btn[ch]),
      .level_o (o_level[ch]),
      .rise_o  (o_rise[ch]),
      .fall_o  (o_fall[ch]),
      .repeat_o(o_repeat[ch])
    );
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: a repeat-enabled and a repeat-disabled
// instance share stimulus and are both held against a rule-level model.
module tb_btn_debounce_array;

  localparam int N_CH         = 2;
  localparam int CLK_DIV      = 4;
  localparam int STABLE_CNT   = 3;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_btn = 2'b00;

  logic [1:0] levelA, riseA, fallA, repA;
  logic       tickA;
  logic [1:0] levelB, riseB, fallB, repB;
  logic       tickB;

  int checks   = 0;
  int failures = 0;
  int evtCount = 0;
  int lvlCount = 0;

  always #5 clk = ~clk;

  btn_debounce_array #(
    .N_CH(N_CH), .CLK_DIV(CLK_DIV), .STABLE_CNT(STABLE_CNT), .REPEAT_EN(1),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dutA (
    .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(levelA), .o_rise(riseA),
    .o_fall(fallA), .o_repeat(repA), .o_tick(tickA)
  );

  btn_debounce_array #(
    .N_CH(N_CH), .CLK_DIV(CLK_DIV), .STABLE_CNT(STABLE_CNT), .REPEAT_EN(0),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dutB (
    .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(levelB), .o_rise(riseB),
    .o_fall(fallB), .o_repeat(repB), .o_tick(tickB)
  );

  // Rule-level model: cycle index since reset, run of differing samples,
  // and ticks elapsed since the accepted press.
  int         mCyc;
  logic [1:0] mSyncA, mSyncB, mLvl;
  int         mStreak [2];
  bit         mHeld [2];
  int         mTicks [2];
  logic [1:0] eLevel, eRise, eFall, eRep;
  logic       eTick;
  bit         modelOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic advanceModel();
    logic tickNow;
    if (rst) begin
      mCyc = 0; mSyncA = 2'b00; mSyncB = 2'b00; mLvl = 2'b00;
      for (int c = 0; c < 2; c++) begin
        mStreak[c] = 0; mHeld[c] = 1'b0; mTicks[c] = 0;
      end
      eRise = 2'b00; eFall = 2'b00; eRep = 2'b00;
      modelOn = 1'b1;
    end else if (modelOn) begin
      tickNow = ((mCyc % CLK_DIV) == CLK_DIV - 1);
      eRise = 2'b00; eFall = 2'b00; eRep = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (tickNow) begin
          if (mSyncB[c] != mLvl[c]) begin
            mStreak[c]++;
            if (mStreak[c] == STABLE_CNT) begin
              mLvl[c] = mSyncB[c];
              mStreak[c] = 0;
              if (mLvl[c]) eRise[c] = 1'b1;
              else         eFall[c] = 1'b1;
            end
          end else begin
            mStreak[c] = 0;
          end
        end
        if (eFall[c]) begin
          mHeld[c] = 1'b0;
        end else if (mHeld[c] && tickNow) begin
          mTicks[c]++;
          if (mTicks[c] == HOLD_TICKS ||
              (mTicks[c] > HOLD_TICKS && ((mTicks[c] - HOLD_TICKS) % REPEAT_TICKS) == 0))
            eRep[c] = 1'b1;
        end
        if (eRise[c]) begin
          mHeld[c] = 1'b1;
          mTicks[c] = 0;
        end
      end
      mSyncB = mSyncA;
      mSyncA = i_btn;
      mCyc++;
    end
    eLevel = mLvl;
    eTick  = ((mCyc % CLK_DIV) == CLK_DIV - 1);
  endtask

  // Inputs change just after posedge, so at negedge they equal what the
  // coming edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (modelOn) begin
        checkOutput("model_A", {23'd0, levelA, riseA, fallA, repA, tickA},
                    {23'd0, eLevel, eRise, eFall, eRep, eTick});
        checkOutput("model_B", {23'd0, levelB, riseB, fallB, repB, tickB},
                    {23'd0, eLevel, eRise, eFall, 2'b00, eTick});
      end
      advanceModel();
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    if ((riseA | fallA | riseB | fallB) != 2'b00) evtCount++;
    if (levelA[0] | levelB[0]) lvlCount++;
  endtask

  task automatic applyStimulus(input logic [1:0] b, input int n);
    i_btn = b;
    repeat (n) nextCycle();
  endtask

  typedef struct {
    logic [1:0] btn;
    int         cycles;
    logic [1:0] expLevel;
  } vec_t;

  vec_t vecs [12];
  int firstTick, secondTick, riseAt, riseLen, fallAt, repAtFall, nRep;
  int rep1, rep2, rep3, riseAtB, fallAtB, nRepB, rise1At, ch1Act;

  initial begin
    vecs[0]  = '{2'b01, 20, 2'b01};
    vecs[1]  = '{2'b00,  3, 2'b01};
    vecs[2]  = '{2'b01, 20, 2'b01};
    vecs[3]  = '{2'b11, 20, 2'b11};
    vecs[4]  = '{2'b10,  3, 2'b11};
    vecs[5]  = '{2'b11, 20, 2'b11};
    vecs[6]  = '{2'b10, 20, 2'b10};
    vecs[7]  = '{2'b00, 20, 2'b00};
    vecs[8]  = '{2'b11,  2, 2'b00};
    vecs[9]  = '{2'b00, 20, 2'b00};
    vecs[10] = '{2'b10, 20, 2'b10};
    vecs[11] = '{2'b01, 20, 2'b01};

    repeat (3) nextCycle();
    checkOutput("reset_A", {23'd0, levelA, riseA, fallA, repA, tickA}, 32'd0);
    checkOutput("reset_B", {23'd0, levelB, riseB, fallB, repB, tickB}, 32'd0);

    // Clean press, hold, repeats, release timed onto a repeat tick.
    $display("[TB] clean press / hold / release");
    rst = 1'b0;
    i_btn = 2'b01;
    firstTick = -1; secondTick = -1; riseAt = -1; riseLen = 0; fallAt = -1;
    repAtFall = -1; nRep = 0; rep1 = -1; rep2 = -1; rep3 = -1;
    riseAtB = -1; fallAtB = -1; nRepB = 0; ch1Act = 0;
    for (int k = 1; k <= 80; k++) begin
      nextCycle();
      if (tickA) begin
        if (firstTick < 0) firstTick = k;
        else if (secondTick < 0) secondTick = k;
      end
      if (riseA[0]) begin
        riseLen++;
        if (riseAt < 0) riseAt = k;
      end
      if (repA[0]) begin
        nRep++;
        if (nRep == 1) rep1 = k;
        if (nRep == 2) rep2 = k;
        if (nRep == 3) rep3 = k;
      end
      if (fallA[0]) begin
        fallAt = k;
        repAtFall = int'(repA[0]);
      end
      if (riseB[0] && riseAtB < 0) riseAtB = k;
      if (fallB[0]) fallAtB = k;
      if (repB != 2'b00) nRepB++;
      if ((levelA[1] | riseA[1] | fallA[1] | repA[1]) != 1'b0) ch1Act++;
      if (k == 44) i_btn = 2'b00;
    end
    checkOutput("first_tick", firstTick, 3);
    checkOutput("tick_period", secondTick - firstTick, CLK_DIV);
    checkOutput("rise_cycle", riseAt, 12);
    checkOutput("rise_width", riseLen, 1);
    checkOutput("repeat_1", rep1, 32);
    checkOutput("repeat_2", rep2, 40);
    checkOutput("repeat_3", rep3, 48);
    checkOutput("repeat_count", nRep, 3);
    checkOutput("fall_cycle", fallAt, 56);
    checkOutput("repeat_on_fall", repAtFall, 0);
    checkOutput("ch1_quiet", ch1Act, 0);
    checkOutput("B_rise_cycle", riseAtB, 12);
    checkOutput("B_fall_cycle", fallAtB, 56);
    checkOutput("B_no_repeat", nRepB, 0);

    // Bounce: one-tick alternation, then a two-tick hold, must be rejected.
    $display("[TB] bounce rejection");
    evtCount = 0;
    lvlCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00, CLK_DIV);
    applyStimulus(2'b01, 2 * CLK_DIV);
    applyStimulus(2'b00, 20);
    checkOutput("bounce_events", evtCount, 0);
    checkOutput("bounce_level", lvlCount, 0);

    // Simultaneous press, held well past 20 ticks.
    $display("[TB] simultaneous press");
    i_btn = 2'b11;
    riseAt = -1; rise1At = -1; nRep = 0; nRepB = 0;
    for (int k = 1; k <= 100; k++) begin
      nextCycle();
      if (riseA[0] && riseAt < 0) riseAt = k;
      if (riseA[1] && rise1At < 0) rise1At = k;
      if (repA != 2'b00) nRep++;
      if (repB != 2'b00) nRepB++;
    end
    checkOutput("simul_rise_found", int'(riseAt > 0), 1);
    checkOutput("simul_rise_same", rise1At, riseAt);
    checkOutput("simul_repeats_A", int'(nRep > 0), 1);
    checkOutput("simul_repeats_B", nRepB, 0);
    checkOutput("simul_level_B", {30'd0, levelB}, 32'd3);

    // Reset while in RPT with buttons still held.
    $display("[TB] reset mid-operation");
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("midreset_A", {23'd0, levelA, riseA, fallA, repA, tickA}, 32'd0);
    checkOutput("midreset_B", {23'd0, levelB, riseB, fallB, repB, tickB}, 32'd0);
    firstTick = -1; riseAt = -1; riseAtB = -1;
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      if (tickA && firstTick < 0) firstTick = k;
      if (riseA == 2'b11 && riseAt < 0) riseAt = k;
      if (riseB == 2'b11 && riseAtB < 0) riseAtB = k;
    end
    checkOutput("midreset_first_tick", firstTick, 3);
    checkOutput("midreset_rise", riseAt, 12);
    checkOutput("midreset_rise_B", riseAtB, 12);

    $display("[TB] vector table");
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].btn, vecs[v].cycles);
      checkOutput($sformatf("vec%0d_level_A", v), {30'd0, levelA}, {30'd0, vecs[v].expLevel});
      checkOutput($sformatf("vec%0d_level_B", v), {30'd0, levelB}, {30'd0, vecs[v].expLevel});
    end

    $display("[TB] random stimulus");
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
      end
      applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
    end

    applyStimulus(2'b00, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
